// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: debounced push-button loader for an A/B/OP register set
// feeding a registered ALU, with direct and sequential loading modes.
module alu_seq_ctrl #(
  parameter int unsigned NB_BITS     = 8,
  parameter int unsigned NB_OPE      = 6,
  parameter int unsigned NB_BTN      = 3,
  parameter int unsigned DBNC_CYCLES = 50000,
  parameter int unsigned NB_DBNC     = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BITS-1:0] i_sw,
  input  logic [NB_BTN-1:0]  i_bnt,
  input  logic               i_mode,
  output logic [NB_BITS-1:0] o_led,
  output logic               o_valid,
  output logic               o_zero,
  output logic               o_carry,
  output logic [1:0]         o_state
);

  localparam logic [NB_DBNC-1:0] DBNC_LAST = NB_DBNC'(DBNC_CYCLES - 1);
  localparam logic [NB_BITS:0]   SHIFT_LIM = (NB_BITS + 1)'(NB_BITS);

  localparam logic [NB_OPE-1:0] OP_ADD = NB_OPE'(6'b100000);
  localparam logic [NB_OPE-1:0] OP_SUB = NB_OPE'(6'b100010);
  localparam logic [NB_OPE-1:0] OP_AND = NB_OPE'(6'b100100);
  localparam logic [NB_OPE-1:0] OP_OR  = NB_OPE'(6'b100101);
  localparam logic [NB_OPE-1:0] OP_XOR = NB_OPE'(6'b100110);
  localparam logic [NB_OPE-1:0] OP_NOR = NB_OPE'(6'b100111);
  localparam logic [NB_OPE-1:0] OP_SRA = NB_OPE'(6'b000011);
  localparam logic [NB_OPE-1:0] OP_SRL = NB_OPE'(6'b000010);

  typedef enum logic [1:0] {
    ST_A    = 2'd0,
    ST_B    = 2'd1,
    ST_OP   = 2'd2,
    ST_SHOW = 2'd3
  } state_e;

  // Button conditioning state
  logic [NB_BTN-1:0]  sync1_q, sync2_q, db_q, db_prev_q, armed_q;
  logic [NB_DBNC-1:0] cnt_q [NB_BTN];
  logic [1:0]         fill_q;
  logic [NB_BTN-1:0]  btn_pulse;

  // Operand/control state
  state_e             state_q, state_d;
  logic [NB_BITS-1:0] a_q, a_d, b_q, b_d;
  logic [NB_OPE-1:0]  op_q, op_d;
  logic [2:0]         ld_q, ld_d;
  logic               mode_q;
  logic               valid_q, valid_d;

  // ALU
  logic [NB_BITS-1:0] alu_res;
  logic               alu_carry;
  logic [NB_BITS:0]   alu_sum;
  logic [NB_BITS-1:0] led_q;
  logic               carry_q, zero_q;

  // Synchronise, debounce and arm each button; a button only arms once it
  // has been seen stably released after reset, so a held button never fires.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      armed_q   <= '0;
      fill_q    <= '0;
      for (int i = 0; i < NB_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= i_bnt;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      for (int i = 0; i < NB_BTN; i++) begin
        if (sync2_q[i] != db_q[i]) begin
          if (cnt_q[i] == DBNC_LAST) begin
            db_q[i]  <= sync2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + NB_DBNC'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
        if ((fill_q == 2'd2) && !sync2_q[i] && !db_q[i]) armed_q[i] <= 1'b1;
      end
    end
  end

  assign btn_pulse = db_q & ~db_prev_q & armed_q;

  // Load/FSM next-state: mode change beats abort beats step
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    ld_d    = ld_q;
    if (i_mode != mode_q) begin
      state_d = ST_A;
      ld_d    = '0;
    end else if (!i_mode) begin
      state_d = ST_A;
      if (btn_pulse[0]) begin a_d  = i_sw;               ld_d[0] = 1'b1; end
      if (btn_pulse[1]) begin b_d  = i_sw;               ld_d[1] = 1'b1; end
      if (btn_pulse[2]) begin op_d = i_sw[NB_OPE-1:0];   ld_d[2] = 1'b1; end
    end else if (btn_pulse[1]) begin
      state_d = ST_A;
      ld_d    = '0;
    end else if (btn_pulse[0]) begin
      case (state_q)
        ST_A:    begin a_d  = i_sw;             ld_d[0] = 1'b1; state_d = ST_B;    end
        ST_B:    begin b_d  = i_sw;             ld_d[1] = 1'b1; state_d = ST_OP;   end
        ST_OP:   begin op_d = i_sw[NB_OPE-1:0]; ld_d[2] = 1'b1; state_d = ST_SHOW; end
        default: state_d = ST_A;
      endcase
    end
    valid_d = i_mode ? (state_d == ST_SHOW) : (&ld_d);
  end

  // Control and operand registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      ld_q    <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      ld_q    <= ld_d;
      mode_q  <= i_mode;
      valid_q <= valid_d;
    end
  end

  // ALU function on the registered operands
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_sum   = {1'b0, a_q} + {1'b0, b_q};
    case (op_q)
      OP_ADD: begin alu_res = alu_sum[NB_BITS-1:0]; alu_carry = alu_sum[NB_BITS]; end
      OP_SUB: begin alu_res = a_q - b_q;            alu_carry = (a_q < b_q);     end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
      OP_SRA: begin
        if ({1'b0, b_q} >= SHIFT_LIM) alu_res = {NB_BITS{a_q[NB_BITS-1]}};
        else                          alu_res = NB_BITS'($signed(a_q) >>> b_q);
      end
      OP_SRL: begin
        if ({1'b0, b_q} >= SHIFT_LIM) alu_res = '0;
        else                          alu_res = a_q >> b_q;
      end
      default: begin alu_res = '0; alu_carry = 1'b0; end
    endcase
  end

  // Registered result and flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      led_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      led_q   <= alu_res;
      carry_q <= alu_carry;
      zero_q  <= (alu_res == '0);
    end
  end

  assign o_led   = led_q;
  assign o_carry = carry_q;
  assign o_zero  = zero_q;
  assign o_valid = valid_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural reference model.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic [2:0] bnt;
  logic       mode;
  logic [7:0] o_led;
  logic       o_valid, o_zero, o_carry;
  logic [1:0] o_state;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int       m_a, m_b, m_op, m_state;
  bit [2:0] m_f;
  bit       m_mode;

  int         optab [8] = '{32, 34, 36, 37, 38, 39, 3, 2};
  logic [7:0] v;
  logic [2:0] mask;
  int         sel;

  alu_seq_ctrl #(
    .NB_BITS(8), .NB_OPE(6), .NB_BTN(3), .DBNC_CYCLES(4), .NB_DBNC(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sw(sw), .i_bnt(bnt), .i_mode(mode),
    .o_led(o_led), .o_valid(o_valid), .o_zero(o_zero), .o_carry(o_carry),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_alu(input int a, input int b, input int op,
                                    output int res, output int cy);
    int sa;
    res = 0;
    cy  = 0;
    sa  = (a >= 128) ? a - 256 : a;
    case (op)
      32: begin res = (a + b) % 256;       cy = (a + b > 255) ? 1 : 0; end
      34: begin res = (a - b + 256) % 256; cy = (a < b) ? 1 : 0;       end
      36: res = a & b;
      37: res = a | b;
      38: res = a ^ b;
      39: res = (~(a | b)) & 255;
      3:  res = (b >= 8) ? ((a >= 128) ? 255 : 0) : ((sa >>> b) & 255);
      2:  res = (b >= 8) ? 0 : (a >> b);
      default: ;
    endcase
  endfunction

  function automatic void model_apply(input logic [2:0] mk, input int val);
    if (!m_mode) begin
      if (mk[0]) begin m_a  = val;      m_f[0] = 1'b1; end
      if (mk[1]) begin m_b  = val;      m_f[1] = 1'b1; end
      if (mk[2]) begin m_op = val & 63; m_f[2] = 1'b1; end
      m_state = 0;
    end else if (mk[1]) begin
      m_state = 0;
      m_f     = '0;
    end else if (mk[0]) begin
      case (m_state)
        0: begin m_a  = val;      m_state = 1; end
        1: begin m_b  = val;      m_state = 2; end
        2: begin m_op = val & 63; m_state = 3; end
        default: m_state = 0;
      endcase
    end
  endfunction

  task automatic check_all(input string tag);
    int res, cy, vexp;
    model_alu(m_a, m_b, m_op, res, cy);
    if (m_mode) vexp = (m_state == 3) ? 1 : 0;
    else        vexp = (m_f == 3'b111) ? 1 : 0;
    check({tag, ".led"},   32'(o_led),   res);
    check({tag, ".carry"}, 32'(o_carry), cy);
    check({tag, ".zero"},  32'(o_zero),  (res == 0) ? 1 : 0);
    check({tag, ".valid"}, 32'(o_valid), vexp);
    check({tag, ".state"}, 32'(o_state), m_state);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".led"},   32'(o_led),   0);
    check({tag, ".carry"}, 32'(o_carry), 0);
    check({tag, ".zero"},  32'(o_zero),  0);
    check({tag, ".valid"}, 32'(o_valid), 0);
    check({tag, ".state"}, 32'(o_state), 0);
  endtask

  task automatic press(input logic [2:0] mk, input logic [7:0] val);
    @(negedge clk);
    sw  = val;
    bnt = mk;
    repeat (10) @(negedge clk);
    bnt = '0;
    repeat (12) @(negedge clk);
    model_apply(mk, int'(val));
  endtask

  task automatic set_mode(input bit b);
    @(negedge clk);
    mode = b;
    repeat (3) @(negedge clk);
    if (b != m_mode) begin
      m_mode  = b;
      m_state = 0;
      m_f     = '0;
    end
  endtask

  initial begin
    rst = 1'b1; sw = '0; bnt = '0; mode = 1'b0;
    m_a = 0; m_b = 0; m_op = 0; m_state = 0; m_f = '0; m_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all("post_reset");

    // Direct mode: ADD with carry into bit 7, then SUB borrow
    press(3'b001, 8'h7F); check_all("dir_a");
    press(3'b010, 8'h01); check_all("dir_b");
    press(3'b100, 8'h20); check_all("dir_add");
    press(3'b010, 8'h80);
    press(3'b100, 8'h22); check_all("dir_sub");

    // Short glitch must not load A
    @(negedge clk);
    sw  = 8'h33;
    bnt = 3'b001;
    repeat (3) @(negedge clk);
    bnt = '0;
    repeat (12) @(negedge clk);
    check_all("glitch");

    press(3'b001, 8'h10); check_all("held");

    // Shifts, including shift amounts at and past the width
    press(3'b001, 8'h80);
    press(3'b010, 8'h02);
    press(3'b100, 8'h03); check_all("sra2");
    press(3'b100, 8'h02); check_all("srl2");
    press(3'b010, 8'h09);
    press(3'b100, 8'h03); check_all("sra9");
    press(3'b010, 8'h08); check_all("sra8");
    press(3'b100, 8'h02); check_all("srl8");
    press(3'b111, 8'h22); check_all("simul");

    // Sequential mode with exact pulse latency on the first step
    set_mode(1'b1); check_all("to_seq");
    @(negedge clk);
    sw  = 8'h05;
    bnt = 3'b001;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      check("latency", 32'(o_state), (k >= 7) ? 1 : 0);
    end
    @(negedge clk);
    bnt = '0;
    repeat (12) @(negedge clk);
    model_apply(3'b001, 5);
    check_all("seq_a");
    press(3'b001, 8'h05); check_all("seq_b");
    press(3'b001, 8'h22); check_all("seq_show");
    press(3'b001, 8'h99); check_all("seq_wrap");

    // Abort from ST_OP with p0 and p1 together; p2 ignored
    press(3'b001, 8'h0F);
    press(3'b001, 8'h03); check_all("seq_op");
    press(3'b011, 8'h24); check_all("abort");
    press(3'b100, 8'h24); check_all("seq_p2");

    set_mode(1'b0); check_all("to_dir");

    // Randomised traffic across both modes
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 5) == 0) set_mode(~m_mode);
      v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) v = (v & 8'hC0) | 8'(optab[$urandom_range(0, 7)]);
      else if ($urandom_range(0, 1) == 1) v = v & 8'h0F;
      if (!m_mode) begin
        mask = 3'($urandom_range(1, 7));
      end else begin
        sel = int'($urandom_range(0, 5));
        mask = (sel < 3) ? 3'b001 : (sel == 3) ? 3'b010 : (sel == 4) ? 3'b011 : 3'b100;
      end
      press(mask, v);
      check_all("rnd");
    end

    // Async reset between edges, mid-debounce, with a button held through it
    set_mode(1'b1);
    press(3'b010, 8'h00);
    press(3'b001, 8'h7F);
    press(3'b001, 8'h01);
    press(3'b001, 8'h20); check_all("pre_rst");
    @(negedge clk);
    bnt = 3'b001;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_a = 0; m_b = 0; m_op = 0; m_state = 0; m_f = '0;
    repeat (20) @(negedge clk);
    check_all("held_thru_rst");
    bnt = '0;
    repeat (12) @(negedge clk);
    check_all("released");
    press(3'b001, 8'h42); check_all("repress");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
